ppe_core: RTL and testbench

PPE_CORE -- requirements
Module: ppe_core

---
 rtl/ppe_core.sv | 174 +++++++++++++++++
 tb/tb_ppe_core.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppe_core.sv
// ppe_core: PE of a binary-ifmap convolution array.
// Slides a FILTER_SIZE-tap weight window across one captured input row and emits
// one partial sum per window position to SPE targets in round-robin order. After a
// row it requests the next input row, until OUTPUT_DIM rows have been consumed in
// the current timestep.
// Optional feature: define PPE_SAT_EN to saturate the accumulator at 2^SUM_WIDTH-1.
// Without it, the accumulator wraps modulo 2^SUM_WIDTH.
module ppe_core #(
   parameter int FILTER_SIZE  = 5,
   parameter int IFMAP_SIZE   = 25,
   parameter int WEIGHT_WIDTH = 8,
   parameter int SUM_WIDTH    = 13,
   parameter int ROW_BASE     = 0,
   localparam int ROW_W       = 6,
   localparam int ADDR_W      = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic [ADDR_W-1:0]       w_addr,
   input  logic [WEIGHT_WIDTH-1:0] w_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IFMAP_SIZE-1:0]   in_row,
   output logic                    ps_valid,
   input  logic                    ps_ready,
   output logic [SUM_WIDTH-1:0]    ps_data,
   output logic [ADDR_W-1:0]       ps_dest,
   output logic                    req_valid,
   input  logic                    req_ready,
   output logic [ROW_W-1:0]        req_row,
   input  logic                    ts_done,
   output logic                    busy
);

   localparam int OUTPUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
   localparam int WIN_W      = (OUTPUT_DIM > 1) ? $clog2(OUTPUT_DIM) : 1;
   localparam int K_W        = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
   localparam int IDX_W      = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_EMIT,
      ST_REQ
   } state_t;

   state_t                  state;
   logic [WEIGHT_WIDTH-1:0] weight [FILTER_SIZE];
   logic [IFMAP_SIZE-1:0]   row_q;
   logic [ROW_W-1:0]        row_cnt;
   logic [ADDR_W-1:0]       dest;
   logic [WIN_W-1:0]        win;
   logic [K_W-1:0]          k;
   logic [SUM_WIDTH-1:0]    acc;
   logic                    ts_pend;

   logic [IDX_W-1:0]        tap_idx;
   logic [WEIGHT_WIDTH-1:0] addend;
   logic [SUM_WIDTH-1:0]    acc_next;
   logic                    w_fire;

   // Handshake and status outputs decoded from the state register.
   always_comb begin
      w_ready   = (state == ST_IDLE);
      in_ready  = (state == ST_IDLE) && !ts_done && !ts_pend;
      ps_valid  = (state == ST_EMIT);
      ps_data   = (state == ST_EMIT) ? acc : '0;
      ps_dest   = dest;
      req_valid = (state == ST_REQ);
      req_row   = (state == ST_REQ) ? ROW_W'(ROW_BASE) + row_cnt : '0;
      busy      = (state != ST_IDLE);
      w_fire    = w_valid && (state == ST_IDLE) && (int'(w_addr) < FILTER_SIZE);
   end

`ifdef PPE_SAT_EN
   localparam int SUM_EXT = ((SUM_WIDTH > WEIGHT_WIDTH) ? SUM_WIDTH : WEIGHT_WIDTH) + 1;
   localparam logic [SUM_WIDTH-1:0] SUM_MAX = '1;
   logic [SUM_EXT-1:0] acc_sum;

   // One MAC tap with clamping; a clamped acc stays at max since addends are unsigned.
   always_comb begin
      tap_idx  = IDX_W'(win) + IDX_W'(k);
      addend   = row_q[tap_idx] ? weight[k] : '0;
      acc_sum  = SUM_EXT'(acc) + SUM_EXT'(addend);
      acc_next = (acc_sum > SUM_EXT'(SUM_MAX)) ? SUM_MAX : acc_sum[SUM_WIDTH-1:0];
   end
`else
   // One MAC tap, wrapping modulo 2^SUM_WIDTH.
   always_comb begin
      tap_idx  = IDX_W'(win) + IDX_W'(k);
      addend   = row_q[tap_idx] ? weight[k] : '0;
      acc_next = acc + SUM_WIDTH'(addend);
   end
`endif

   // Weight register file, writable only while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
            weight[i] <= '0;
         end
      end else if (w_fire) begin
         weight[w_addr] <= w_data;
      end
   end

   // Row/window sequencer: capture row, MAC each window, emit, then request next row.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         row_q   <= '0;
         row_cnt <= '0;
         dest    <= '0;
         win     <= '0;
         k       <= '0;
         acc     <= '0;
         ts_pend <= 1'b0;
      end else begin
         if (ts_done && state != ST_IDLE) begin
            ts_pend <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               // A pending end-of-timestep is applied on the first idle cycle and blocks input.
               if (ts_done || ts_pend) begin
                  row_cnt <= '0;
                  dest    <= '0;
                  ts_pend <= 1'b0;
               end else if (in_valid) begin
                  row_q   <= in_row;
                  row_cnt <= row_cnt + 1'b1;
                  win     <= '0;
                  k       <= '0;
                  acc     <= '0;
                  state   <= ST_MAC;
               end
            end
            ST_MAC: begin
               acc <= acc_next;
               if (int'(k) == FILTER_SIZE - 1) begin
                  k     <= '0;
                  state <= ST_EMIT;
               end else begin
                  k <= k + 1'b1;
               end
            end
            ST_EMIT: begin
               if (ps_ready) begin
                  dest <= (int'(dest) == FILTER_SIZE - 1) ? '0 : dest + 1'b1;
                  if (int'(win) < OUTPUT_DIM - 1) begin
                     win   <= win + 1'b1;
                     k     <= '0;
                     acc   <= '0;
                     state <= ST_MAC;
                  end else if (int'(row_cnt) < OUTPUT_DIM) begin
                     state <= ST_REQ;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_REQ: begin
               if (req_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ppe_core.sv
// tb_ppe_core: self-checking bench for ppe_core (SUM_WIDTH=10 so overflow is reachable).
// Table-driven rows with fixed expectations, randomized rows against a window-sum
// model, plus hand-written backpressure, end-of-timestep and mid-MAC reset sequences.
module tb_ppe_core;
   localparam int FS   = 5;
   localparam int IS   = 25;
   localparam int OD   = IS - FS + 1;
   localparam int SW   = 10;
   localparam int SMAX = (1 << SW) - 1;
`ifdef PPE_SAT_EN
   localparam int FULL = 1023;
`else
   localparam int FULL = 251;
`endif

   logic          clk, reset;
   logic          w_valid, w_ready;
   logic [2:0]    w_addr;
   logic [7:0]    w_data;
   logic          in_valid, in_ready;
   logic [IS-1:0] in_row;
   logic          ps_valid, ps_ready;
   logic [SW-1:0] ps_data;
   logic [2:0]    ps_dest;
   logic          req_valid, req_ready;
   logic [5:0]    req_row;
   logic          ts_done, busy;

   ppe_core #(.FILTER_SIZE(FS), .IFMAP_SIZE(IS), .WEIGHT_WIDTH(8), .SUM_WIDTH(SW), .ROW_BASE(0)) dut (
      .clk(clk), .reset(reset),
      .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
      .ps_valid(ps_valid), .ps_ready(ps_ready), .ps_data(ps_data), .ps_dest(ps_dest),
      .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row),
      .ts_done(ts_done), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   int m_row_cnt = 0;
   int m_dest    = 0;
   int m_w [FS];

   typedef struct {
      logic [FS-1:0][7:0] w;
      logic [IS-1:0]      row;
      int                 first;
      int                 last;
      int                 total;
   } vec_t;

   vec_t vt [6];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Window sum straight from the definition: sum of weights whose tap bit is set.
   function automatic int model_sum(input logic [IS-1:0] row, input int win);
      int s;
      s = 0;
      for (int kk = 0; kk < FS; kk++) if (row[win + kk]) s += m_w[kk];
`ifdef PPE_SAT_EN
      if (s > SMAX) s = SMAX;
`else
      s = s % (SMAX + 1);
`endif
      return s;
   endfunction

   function automatic vec_t mk(input logic [FS-1:0][7:0] w, input logic [IS-1:0] row,
                               input int f, input int l, input int t);
      vec_t v;
      v.w = w; v.row = row; v.first = f; v.last = l; v.total = t;
      return v;
   endfunction

   task automatic check_reset(input string tag);
      check({tag, " ps_valid"},  ps_valid,  0);
      check({tag, " req_valid"}, req_valid, 0);
      check({tag, " busy"},      busy,      0);
      check({tag, " ps_data"},   ps_data,   0);
      check({tag, " ps_dest"},   ps_dest,   0);
      check({tag, " req_row"},   req_row,   0);
      check({tag, " in_ready"},  in_ready,  1);
      check({tag, " w_ready"},   w_ready,   1);
   endtask

   task automatic load_weights(input logic [FS-1:0][7:0] w);
      for (int kk = 0; kk < FS; kk++) begin
         @(negedge clk);
         w_valid = 1'b1; w_addr = 3'(kk); w_data = w[kk];
         check("w_ready", w_ready, 1);
         @(posedge clk);
         m_w[kk] = int'(w[kk]);
      end
      // out-of-range address must be ignored
      @(negedge clk);
      w_addr = 3'(FS + $urandom_range(0, 2)); w_data = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      w_valid = 1'b0;
   endtask

   task automatic process_row(input logic [IS-1:0] row, input int stall_win, input bit ts_last,
                              output int first, output int last, output int total);
      int gap;
      logic [SW-1:0] d0;
      logic [2:0] dd0;
      bit exp_req;
      @(negedge clk);
      in_row = row; in_valid = 1'b1;
      gap = 0;
      while (!in_ready && gap < 20) begin @(negedge clk); gap++; end
      check("in_ready for row", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_row = '0;
      m_row_cnt++;
      first = 0; last = 0; total = 0;
      for (int win = 0; win < OD; win++) begin
         gap = 1;
         while (!ps_valid && gap < 20) begin @(negedge clk); gap++; end
         check($sformatf("latency w%0d", win), gap, FS + 1);
         if (win == stall_win) begin
            ps_ready = 1'b0; d0 = ps_data; dd0 = ps_dest;
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               check("stall hold", int'(ps_valid && ps_data == d0 && ps_dest == dd0), 1);
            end
            ps_ready = 1'b1;
         end
         if (ts_last && win == OD - 1) ts_done = 1'b1;
         check($sformatf("ps_data w%0d", win), ps_data, model_sum(row, win));
         check($sformatf("ps_dest w%0d", win), ps_dest, m_dest);
         m_dest = (m_dest + 1) % FS;
         if (win == 0) first = ps_data;
         if (win == OD - 1) last = ps_data;
         total += ps_data;
         @(negedge clk);
         ts_done = 1'b0;
      end
      exp_req = (m_row_cnt < OD);
      check("req_valid after row", req_valid, exp_req);
      if (exp_req) begin
         check("req_row", req_row, m_row_cnt);
         @(negedge clk);
      end else if (ts_last) begin
         #1;
         check("in_ready while ts pending", in_ready, 0);
      end
      check("idle after row", busy, 0);
      if (ts_last) begin m_row_cnt = 0; m_dest = 0; end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int f, l, t;
      logic [FS-1:0][7:0] rw;
      logic [IS-1:0] rr;
      bit quiet;

      reset = 1'b1; w_valid = 1'b0; w_addr = '0; w_data = '0;
      in_valid = 1'b0; in_row = '0; ps_ready = 1'b1; req_ready = 1'b1; ts_done = 1'b0;
      for (int kk = 0; kk < FS; kk++) m_w[kk] = 0;
      repeat (2) @(negedge clk);
      check_reset("reset");
      reset = 1'b0;

      vt[0] = mk({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 25'h1FFFFFF, 15, 15, 315);
      vt[1] = mk({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 25'h0000001, 1, 0, 1);
      vt[2] = mk({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 25'h0AAAAAA, 6, 6, 156);
      vt[3] = mk({8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 25'h1000000, 0, 50, 50);
      vt[4] = mk({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 25'h000001F, 15, 0, 35);
      vt[5] = mk({8'd255, 8'd255, 8'd255, 8'd255, 8'd255}, 25'h1FFFFFF, FULL, FULL, FULL * OD);

      for (int i = 0; i < 6; i++) begin
         load_weights(vt[i].w);
         process_row(vt[i].row, -1, 1'b0, f, l, t);
         check($sformatf("vec%0d first", i), f, vt[i].first);
         check($sformatf("vec%0d last", i), l, vt[i].last);
         check($sformatf("vec%0d total", i), t, vt[i].total);
      end

      // random rows; the first one also stalls window 3 for 10 cycles
      for (int r = 0; r < 8; r++) begin
         for (int kk = 0; kk < FS; kk++) rw[kk] = 8'($urandom);
         rr = IS'($urandom);
         load_weights(rw);
         process_row(rr, (r == 0) ? 3 : -1, 1'b0, f, l, t);
      end
      while (m_row_cnt < OD - 1) begin
         rr = IS'($urandom);
         process_row(rr, -1, 1'b0, f, l, t);
      end

      // row 21 with ts_done during its last emit, then a fresh timestep
      process_row(IS'($urandom), -1, 1'b1, f, l, t);
      process_row(IS'($urandom), -1, 1'b0, f, l, t);

      // ts_done in idle beats a simultaneous in_valid
      @(negedge clk);
      in_valid = 1'b1; in_row = '1; ts_done = 1'b1;
      #1;
      check("in_ready under ts_done", in_ready, 0);
      @(negedge clk);
      ts_done = 1'b0; in_valid = 1'b0;
      #1;
      check("ts_done priority idle", busy, 0);
      m_row_cnt = 0; m_dest = 0;
      process_row(IS'($urandom), -1, 1'b0, f, l, t);

      // reset during the third MAC cycle
      load_weights({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
      @(negedge clk);
      in_valid = 1'b1; in_row = '1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset("mid-MAC reset");
      @(negedge clk);
      reset = 1'b0;
      m_row_cnt = 0; m_dest = 0;
      for (int kk = 0; kk < FS; kk++) m_w[kk] = 0;
      quiet = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (ps_valid || req_valid || busy) quiet = 1'b0;
      end
      check("post-reset quiet", quiet, 1);
      process_row('1, -1, 1'b0, f, l, t);
      check("post-reset cleared weights total", t, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
